// File: rtl/drum_seq_pkg.sv
// Shared types and defaults for the drum step sequencer: pattern write opcodes,
// default geometry and the per-bit write rule.
package drum_seq_pkg;

   typedef enum logic [1:0] {
      OP_CLR    = 2'b00,
      OP_SET    = 2'b01,
      OP_TGL    = 2'b10,
      OP_CLR_CH = 2'b11
   } wr_op_e;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_STEPS    = 8;
   localparam int DEF_DIV_W    = 16;

   // New value of one pattern bit under a write opcode; OP_CLR_CH clears like OP_CLR.
   function automatic logic apply_op(input wr_op_e op, input logic cur);
      case (op)
         OP_SET:  return 1'b1;
         OP_TGL:  return ~cur;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/drum_seq_tempo.sv
// Tempo divider: counts run cycles and raises tick once per step period.
// DRUM_SEQ_SWING_EN lengthens steps that land on an odd position by 'swing' cycles.
module drum_seq_tempo
   import drum_seq_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
`ifdef DRUM_SEQ_SWING_EN
   input  logic [DIV_W-1:0] swing,
   input  logic             next_odd,
`endif
   output logic             tick
);

   logic [DIV_W-1:0] cnt_reg;

`ifdef DRUM_SEQ_SWING_EN
   // One extra bit so div+swing never wraps.
   logic [DIV_W:0] limit;
   assign limit = next_odd ? ({1'b0, div} + {1'b0, swing}) : {1'b0, div};
   assign tick  = run & ({1'b0, cnt_reg} >= limit);
`else
   // >= rather than == so lowering div mid-count still ticks on the next cycle.
   assign tick  = run & (cnt_reg >= div);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (restart || tick) begin
         cnt_reg <= '0;
      end else if (run) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/drum_step_sequencer.sv
// Multi-channel drum step sequencer: pattern storage, shared step pointer, write port
// and registered trigger outputs. Optional swing input under DRUM_SEQ_SWING_EN.
module drum_step_sequencer
   import drum_seq_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int STEPS    = DEF_STEPS,
   parameter int DIV_W    = DEF_DIV_W,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int STEP_W   = $clog2(STEPS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                restart,
   input  logic [DIV_W-1:0]    div,
`ifdef DRUM_SEQ_SWING_EN
   input  logic [DIV_W-1:0]    swing,
`endif
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [CH_W-1:0]     wr_chan,
   input  logic [STEP_W-1:0]   wr_step,
   input  logic [1:0]          wr_op,
   output logic [CHANNELS-1:0] trig,
   output logic [STEP_W-1:0]   step_pos,
   output logic                step_strobe
);

   logic [STEPS-1:0]    pattern_reg [CHANNELS];
   logic [STEP_W-1:0]   step_pos_reg;
   logic [STEP_W-1:0]   next_pos;
   logic [CHANNELS-1:0] trig_reg;
   logic [CHANNELS-1:0] col_next;
   logic [CHANNELS-1:0] col_first;
   logic                strobe_reg;
   logic                tick;
   logic                wr_fire;
   logic                addr_ok;

   assign next_pos = (step_pos_reg == STEP_W'(STEPS - 1)) ? '0 : step_pos_reg + 1'b1;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_col
         assign col_next[gi]  = pattern_reg[gi][next_pos];
         assign col_first[gi] = pattern_reg[gi][0];
      end
   endgenerate

   drum_seq_tempo #(
      .DIV_W    (DIV_W)
   ) u_tempo (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .restart  (restart),
      .div      (div),
`ifdef DRUM_SEQ_SWING_EN
      .swing    (swing),
      .next_odd (next_pos[0]),
`endif
      .tick     (tick)
   );

   // Writes are refused whenever playback reads the pattern, so the two never collide.
   assign wr_ready = ~rst & ~tick & ~restart;
   assign wr_fire  = wr_valid & wr_ready;
   // Any out-of-range address (even for a whole-channel clear) completes without effect.
   assign addr_ok  = (int'(wr_chan) < CHANNELS) && (int'(wr_step) < STEPS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            pattern_reg[c] <= '0;
         end
      end else if (wr_fire && addr_ok) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int s = 0; s < STEPS; s++) begin
               if (int'(wr_chan) == c && (wr_op == OP_CLR_CH || int'(wr_step) == s)) begin
                  pattern_reg[c][s] <= apply_op(wr_op_e'(wr_op), pattern_reg[c][s]);
               end
            end
         end
      end
   end

   // Restart wins over a coincident tick; trig and strobe are single-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_pos_reg <= '0;
         trig_reg     <= '0;
         strobe_reg   <= 1'b0;
      end else if (restart) begin
         step_pos_reg <= '0;
         trig_reg     <= run ? col_first : '0;
         strobe_reg   <= run;
      end else if (tick) begin
         step_pos_reg <= next_pos;
         trig_reg     <= col_next;
         strobe_reg   <= 1'b1;
      end else begin
         trig_reg     <= '0;
         strobe_reg   <= 1'b0;
      end
   end

   assign trig        = trig_reg;
   assign step_pos    = step_pos_reg;
   assign step_strobe = strobe_reg;

endmodule

// File: doc/drum_step_sequencer.md
# drum_step_sequencer

Multi-channel, parametrised drum step sequencer: CHANNELS independent circular patterns of STEPS steps each, played back by a shared step pointer advanced by an internal tempo divider. Each step emits a one-cycle trigger pulse per channel whose pattern bit is set. Patterns are edited through a valid/ready write port. The block drives the drum-trigger outputs of the top-level user module and replaces the single fixed 8-step ring.

## Interface
Parameters:
- CHANNELS, 4, number of independent drum channels (1..8)
- STEPS, 8, steps per pattern (2..32; non-power-of-two allowed)
- DIV_W, 16, width of tempo divisor
- CH_W, $clog2(CHANNELS) (min 1), derived
- STEP_W, $clog2(STEPS), derived

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; 1 = sequencer advances, 0 = pointer and divider hold
- restart  in  1  single-cycle pulse; realign to step 0
- div  in  DIV_W  step period = div+1 clk cycles
- wr_valid  in  1  pattern write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_chan  in  CH_W  target channel
- wr_step  in  STEP_W  target step
- wr_op  in  2  00 clear bit, 01 set bit, 10 toggle bit, 11 clear entire channel
- trig  out  CHANNELS  one-cycle trigger pulses
- step_pos  out  STEP_W  step currently sounding
- step_strobe  out  1  one-cycle pulse on every step advance

## Operation
- Storage: CHANNELS×STEPS pattern bits, all 0 at reset.
- Divider cnt (DIV_W bits): increments each cycle while run=1; tick when run=1 and cnt >= div (>= so a lowered div mid-count ticks next cycle); cnt <- 0 on tick.
- On tick: step_pos <- step_pos+1, wrapping STEPS-1 -> 0; trig[c] <- pattern[c][new step_pos]; step_strobe <- 1. Otherwise trig and step_strobe <- 0.
- restart: cnt <- 0, step_pos <- 0; if run=1, trig[c] <- pattern[c][0] and step_strobe <- 1 next cycle; if run=0, no pulses. restart overrides a coincident tick.
- run=0: cnt, step_pos held; trig, step_strobe 0. Resuming continues from held cnt.
- Writes: accepted on wr_valid & wr_ready; pattern updated at that edge. wr_ready = 0 while rst=1 and in any cycle where tick or restart is active; 1 otherwise. Write and playback read therefore never share a cycle. Out-of-range wr_chan/wr_step (>= CHANNELS/STEPS): handshake completes, no bit changes.
- Reset values: trig=0, step_strobe=0, step_pos=0, wr_ready=0 (1 from first cycle after rst falls), cnt=0, patterns 0. Reset mid-step aborts any pulse immediately (async).

## Timing
- Trigger latency: 1 cycle from tick/restart cycle to registered trig.
- All outputs registered except wr_ready (combinational from rst, tick, restart).
- div=0: one step per cycle; trig can be high on consecutive cycles for consecutive set steps.
- Step period constant at div+1 cycles with run held high and div static.

## Configuration
- DRUM_SEQ_SWING_EN: defined adds input swing (DIV_W bits); tick for odd new step_pos requires cnt >= div+swing (DIV_W+1-bit compare, no overflow), even steps unchanged. Undefined: port absent, all steps uniform div+1.

## Structure
- Package drum_seq_pkg: wr_op enum (OP_CLR, OP_SET, OP_TGL, OP_CLR_CH), default parameter constants.
- Sub-module drum_seq_tempo: divider, run/restart handling, tick and swing logic; top holds pattern storage, pointer, write port, output registers.

## Test plan
- Reset, CHANNELS=4, STEPS=8, div=3, run=1, set ch0 steps 0 and 4 -> trig[0] every 16 cycles after step 0, alternating 0/4, step_strobe every 4 cycles, step_pos wraps 7->0.
- div=0, ch1 steps 2,3 set -> trig[1] high two consecutive cycles; no other channel fires.
- Write issued in tick cycle -> wr_ready=0, held request accepted next cycle; toggle of current step affects only next pass.
- restart pulse mid-pattern with run=1 -> next cycle step_pos=0, trig=pattern[*][0]; restart with run=0 -> step_pos=0, no trig.
- STEPS=6, op 11 on ch2 -> wrap 5->0, ch2 silent; write to wr_step=7 handshakes with no change.
- Swing build, div=3, swing=2 -> step intervals alternate 4 (to even) and 6 (to odd) cycles; rst asserted mid-run -> all outputs 0 asynchronously.
